// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner that fetches instruction words over req/ack and hands them on with valid/ready.
module inst_fetch_unit #(
  parameter int PC_W = 12,
  parameter int INST_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic [1:0]        pc_src,
  input  logic [PC_W-1:0]   jump_target,
  input  logic [7:0]        branch_off,
  output logic [PC_W-1:0]   pc,
  output logic [15:0]       retired
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t r_state, w_next;
  logic [PC_W-1:0] r_pc, w_off, w_pc_next;
  logic [INST_W-1:0] r_inst;
  logic [15:0] r_retired;
  logic w_req, w_valid, w_consume;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_req = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      IDLE: w_next = start ? FETCH : IDLE;
      FETCH: begin
        w_req = 1'b1;
        w_next = imem_ack ? HOLD : FETCH;
      end
      HOLD: begin
        w_valid = 1'b1;
        w_next = inst_ready ? FETCH : HOLD;
      end
      default: w_next = IDLE;
    endcase
  end
  assign w_consume = w_valid && inst_ready;
  assign w_off = {{(PC_W-8){branch_off[7]}}, branch_off};
  // pc_src encoding: 10 sequential, 00 jump, 01 pc-relative branch, 11 refetch
  assign w_pc_next = pc_src == 2'b00 ? jump_target :
                     pc_src == 2'b01 ? r_pc + PC_W'(1) + w_off :
                     pc_src == 2'b11 ? r_pc : r_pc + PC_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc <= RESET_PC;
      r_inst <= '0;
      r_retired <= '0;
    end else begin
      if (w_req && imem_ack) r_inst <= imem_rdata;
      if (w_consume) begin
        r_pc <= w_pc_next;
        r_retired <= r_retired == 16'hFFFF ? r_retired : r_retired + 16'd1;
      end
    end
  assign imem_req = w_req;
  assign imem_addr = r_pc;
  assign inst = r_inst;
  assign inst_valid = w_valid;
  assign pc = r_pc;
  assign retired = r_retired;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed fetch sequence with a scoreboard of expected fetch addresses.
module tb_inst_fetch_unit;
  logic clk = 1'b0;
  logic rst, start, imem_ack, inst_ready;
  logic [15:0] imem_rdata;
  logic [1:0] pc_src;
  logic [11:0] jump_target;
  logic [7:0] branch_off;
  logic imem_req, inst_valid;
  logic [11:0] imem_addr, pc;
  logic [15:0] inst, retired;
  int cmps = 0;
  int errs = 0;
  logic [11:0] exp_q[$];
  logic [11:0] cur_pc;
  logic [15:0] ret_m;
  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .pc_src(pc_src), .jump_target(jump_target),
    .branch_off(branch_off), .pc(pc), .retired(retired)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] model_pc(input logic [11:0] p, input logic [1:0] s,
                                           input logic [11:0] jt, input logic [7:0] off);
    int t;
    case (s)
      2'b00: t = int'(jt);
      2'b01: t = int'(p) + 1 + int'($signed(off));
      2'b11: t = int'(p);
      default: t = int'(p) + 1;
    endcase
    return t[11:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start(input logic [11:0] a);
    exp_q.push_back(a);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_req", imem_req, 1);
  endtask
  task automatic fetch(input int ws, input logic [15:0] data);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      chk("req_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    cur_pc = exp_q.pop_front();
    chk("imem_addr", imem_addr, cur_pc);
    repeat (ws) begin
      @(negedge clk);
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, cur_pc);
      chk("wait_retired", retired, ret_m);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 16'hDEAD;
    chk("inst_valid", inst_valid, 1);
    chk("inst", inst, data);
    chk("hold_pc", pc, cur_pc);
    chk("hold_req", imem_req, 0);
  endtask
  task automatic consume(input logic [1:0] s, input logic [11:0] jt, input logic [7:0] off);
    pc_src = s;
    jump_target = jt;
    branch_off = off;
    inst_ready = 1'b1;
    exp_q.push_back(model_pc(cur_pc, s, jt, off));
    if (ret_m != 16'hFFFF) ret_m++;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("consume_valid", inst_valid, 0);
    chk("next_req", imem_req, 1);
    chk("retired", retired, ret_m);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0; imem_rdata = '0;
    pc_src = 2'b10; jump_target = '0; branch_off = '0; ret_m = '0; cur_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_retired", retired, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req", imem_req, 0);
    pulse_start(12'h000);
    fetch(0, 16'h0123); consume(2'b10, 12'h000, 8'h00);
    fetch(0, 16'h1456); consume(2'b10, 12'h000, 8'h00);
    fetch(0, 16'h4789); consume(2'b10, 12'h000, 8'h00);
    fetch(0, 16'h3333);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ign_valid", inst_valid, 1);
    chk("start_ign_req", imem_req, 0);
    @(negedge clk);
    chk("start_ign_req2", imem_req, 0);
    chk("start_ign_pc", pc, 12'h003);
    consume(2'b11, 12'h000, 8'h00);
    fetch(0, 16'h3333); consume(2'b10, 12'h000, 8'h00);
    fetch(0, 16'h4444); consume(2'b10, 12'h000, 8'h00);
    fetch(0, 16'h2040); consume(2'b00, 12'h040, 8'h00);
    fetch(0, 16'h0400); consume(2'b00, 12'h00A, 8'h00);
    fetch(0, 16'h0A0A); consume(2'b01, 12'h000, 8'hFC);
    inst_ready = 1'b1;
    fetch(3, 16'h0707);
    inst_ready = 1'b0;
    chk("bp_pc7", pc, 12'h007);
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", inst_valid, 1);
      chk("bp_inst", inst, 16'h0707);
      chk("bp_pc", pc, 12'h007);
      chk("bp_retired", retired, ret_m);
    end
    consume(2'b00, 12'hFFF, 8'h00);
    fetch(0, 16'h0FFF); consume(2'b10, 12'h000, 8'h00);
    fetch(0, 16'hA5A5); consume(2'b00, 12'h007, 8'h00);
    cur_pc = exp_q.pop_front();
    chk("rst_mid_addr", imem_addr, cur_pc);
    chk("rst_mid_req_pre", imem_req, 1);
    imem_ack = 1'b1;
    imem_rdata = 16'hBEEF;
    rst = 1'b1;
    #1;
    chk("rst_mid_req", imem_req, 0);
    chk("rst_mid_pc", pc, 0);
    chk("rst_mid_valid", inst_valid, 0);
    chk("rst_mid_retired", retired, 0);
    chk("rst_mid_inst", inst, 0);
    @(negedge clk);
    chk("rst_mid_inst2", inst, 0);
    rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("post_rst_req", imem_req, 0);
    chk("post_rst_valid", inst_valid, 0);
    chk("post_rst_inst", inst, 0);
    ret_m = '0;
    exp_q.delete();
    pulse_start(12'h000);
    fetch(0, 16'h1111); consume(2'b10, 12'h000, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
